// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and load/store.
// Optional misaligned-access trap is built when MISALIGN_CHECK_EN is defined.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [2:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
`ifdef MISALIGN_CHECK_EN
    output logic              d_misalign,
`endif
    output logic              stall
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] K_WORD = 2'd0;
    localparam logic [1:0] K_BYTE = 2'd1;
    localparam logic [1:0] K_HALF = 2'd2;

    localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] LAT_LIM    = LW'(MEM_LAT);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [1:0]    state;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve;
    logic          grant_d;
    logic [1:0]    r_kind;
    logic          r_uns;
    logic [1:0]    r_lo;

    logic          data_req;
    logic          force_if;
    logic [1:0]    req_kind;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          req_misalign;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld_ext;
    logic          unused_if_lo;

    assign unused_if_lo = ^if_addr[1:0];
    assign data_req = d_read | d_write;
    assign force_if = (STARVE_MAX > 0) && if_req && (starve == STARVE_LIM);
    assign stall    = (if_req & ~if_ready) | (data_req & ~d_ready);

    // Unrecognised size codes fall back to a full-word access.
    always_comb begin
        req_kind     = K_WORD;
        req_be       = 4'b1111;
        req_wdata    = d_wdata;
        req_misalign = 1'b0;
        case (d_size)
            3'b001: begin
                req_kind  = K_BYTE;
                req_be    = 4'b0001 << d_addr[1:0];
                req_wdata = {4{d_wdata[7:0]}};
            end
            3'b010: begin
                req_kind     = K_HALF;
                req_be       = d_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata    = {2{d_wdata[15:0]}};
                req_misalign = d_addr[0];
            end
            default: req_misalign = (d_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (r_lo)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext   = mem_rdata;
        if (r_kind == K_BYTE)
            ld_ext = r_uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (r_kind == K_HALF)
            ld_ext = r_uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            starve    <= '0;
            grant_d   <= 1'b0;
            r_kind    <= K_WORD;
            r_uns     <= 1'b0;
            r_lo      <= 2'b00;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
`ifdef MISALIGN_CHECK_EN
            d_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (data_req && !force_if) begin
                        grant_d   <= 1'b1;
                        starve    <= if_req ? starve + 1'b1 : '0;
                        r_kind    <= req_kind;
                        r_uns     <= d_unsigned;
                        r_lo      <= d_addr[1:0];
                        mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                        mem_be    <= req_be;
                        mem_wdata <= req_wdata;
`ifdef MISALIGN_CHECK_EN
                        if (req_misalign) begin
                            d_ready    <= 1'b1;
                            d_misalign <= 1'b1;
                            d_rdata    <= '0;
                            state      <= DONE;
                        end else begin
                            mem_en <= 1'b1;
                            mem_we <= d_write;
                            state  <= ISSUE;
                        end
`else
                        mem_en <= 1'b1;
                        mem_we <= d_write;
                        state  <= ISSUE;
`endif
                    end else if (if_req) begin
                        grant_d  <= 1'b0;
                        starve   <= '0;
                        mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
                        mem_be   <= 4'b1111;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= LW'(1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == LAT_LIM) begin
                        if (grant_d) begin
                            d_rdata <= ld_ext;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    // Requests still visible here are the ones just served.
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
                    d_misalign <= 1'b0;
`endif
                    state <= IDLE;
                end
            endcase
        end
    end

    // Misalignment is only acted on when the trap is built in.
`ifndef MISALIGN_CHECK_EN
    logic unused_misalign;
    assign unused_misalign = req_misalign;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_read, d_write, d_unsigned;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata, mem_rdata;

    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        if_ready1, d_ready1, mem_en1, mem_we1, stall1;
    logic [3:0]  mem_be1;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic        if_ready3, d_ready3, mem_en3, mem_we3, stall3;
    logic [3:0]  mem_be3;
`ifdef MISALIGN_CHECK_EN
    logic        mis1, mis3;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata1), .if_ready(if_ready1),
        .d_read(d_read), .d_write(d_write), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata1), .d_ready(d_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata),
`ifdef MISALIGN_CHECK_EN
        .d_misalign(mis1),
`endif
        .stall(stall1)
    );

    unified_mem_arbiter #(.ADDR_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata3), .if_ready(if_ready3),
        .d_read(d_read), .d_write(d_write), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata3), .d_ready(d_ready3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata),
`ifdef MISALIGN_CHECK_EN
        .d_misalign(mis3),
`endif
        .stall(stall3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One data access on dut1, entered and left right after a falling edge.
    task automatic data_access(input string tag, input logic rd, input logic wr,
                               input logic [2:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        d_read = rd; d_write = wr; d_size = size; d_unsigned = uns;
        d_addr = addr; d_wdata = wdata; mem_rdata = rdata;
        @(negedge clk);
        chk({tag, " mem_en"}, 32'(mem_en1), 32'd1);
        chk({tag, " mem_we"}, 32'(mem_we1), 32'(wr));
        chk({tag, " mem_be"}, 32'(mem_be1), 32'(exp_be));
        chk({tag, " mem_addr"}, mem_addr1, {addr[31:2], 2'b00});
        if (wr) chk({tag, " mem_wdata"}, mem_wdata1, exp_wdata);
        chk({tag, " stall"}, 32'(stall1), 32'd1);
        @(negedge clk);
        chk({tag, " mem_en off"}, 32'(mem_en1), 32'd0);
        chk({tag, " early ready"}, 32'(d_ready1), 32'd0);
        @(negedge clk);
        chk({tag, " d_ready"}, 32'(d_ready1), 32'd1);
        chk({tag, " no if_ready"}, 32'(if_ready1), 32'd0);
        chk({tag, " stall released"}, 32'(stall1), 32'd0);
        if (rd && !wr) chk({tag, " d_rdata"}, d_rdata1, exp_rdata);
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        chk({tag, " d_ready pulse"}, 32'(d_ready1), 32'd0);
    endtask

    logic exp_k[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic g1_k[16], r1_k[16], g3_k[16], r3_k[16];
    int   g1_c[16], r1_c[16], g3_c[16], r3_c[16];
    int   g1_n, r1_n, g3_n, r3_n;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_size = 3'b100; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset mem_en", 32'(mem_en1), 32'd0);
        chk("reset mem_be", 32'(mem_be1), 32'd0);
        chk("reset mem_addr", mem_addr1, 32'd0);
        chk("reset readies", {30'd0, if_ready1, d_ready1}, 32'd0);
        chk("reset rdata", if_rdata1 | d_rdata1, 32'd0);
        chk("reset stall", 32'(stall1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Instruction fetch.
        if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h00500093;
        #1 chk("fetch stall comb", 32'(stall1), 32'd1);
        @(negedge clk);
        chk("fetch mem_en", 32'(mem_en1), 32'd1);
        chk("fetch mem_addr", mem_addr1, 32'h40);
        chk("fetch mem_be/we", {27'd0, mem_we1, mem_be1}, 32'h0000000F);
        @(negedge clk);
        chk("fetch mem_en off", 32'(mem_en1), 32'd0);
        chk("fetch stall wait", 32'(stall1), 32'd1);
        chk("fetch early ready", 32'(if_ready1), 32'd0);
        @(negedge clk);
        chk("fetch if_ready", 32'(if_ready1), 32'd1);
        chk("fetch if_rdata", if_rdata1, 32'h00500093);
        chk("fetch no d_ready", 32'(d_ready1), 32'd0);
        chk("fetch stall done", 32'(stall1), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch pulse", 32'(if_ready1), 32'd0);

        data_access("lb signed", 1, 0, 3'b001, 0, 32'h103, 0, 32'h80FF1234, 4'b1000, 0, 32'hFFFFFF80);
        data_access("lbu", 1, 0, 3'b001, 1, 32'h103, 0, 32'h80FF1234, 4'b1000, 0, 32'h00000080);
        data_access("lh lo", 1, 0, 3'b010, 0, 32'h100, 0, 32'h80FF1234, 4'b0011, 0, 32'h00001234);
        data_access("lh hi", 1, 0, 3'b010, 0, 32'h102, 0, 32'h80FF1234, 4'b1100, 0, 32'hFFFF80FF);
        data_access("lhu hi", 1, 0, 3'b010, 1, 32'h102, 0, 32'h80FF1234, 4'b1100, 0, 32'h000080FF);
        data_access("lw", 1, 0, 3'b100, 1, 32'h104, 0, 32'hDEADBEEF, 4'b1111, 0, 32'hDEADBEEF);
        data_access("bad size", 1, 0, 3'b011, 0, 32'h108, 0, 32'h8000_0001, 4'b1111, 0, 32'h80000001);
        data_access("sh", 0, 1, 3'b010, 0, 32'h102, 32'h0000BEEF, 0, 4'b1100, 32'hBEEFBEEF, 0);
        data_access("sb", 0, 1, 3'b001, 0, 32'h101, 32'h000000A5, 0, 4'b0010, 32'hA5A5A5A5, 0);
        data_access("rd+wr", 1, 1, 3'b100, 0, 32'h10C, 32'h12345678, 0, 4'b1111, 32'h12345678, 0);

        // Reset while a load sits in WAIT.
        d_read = 1'b1; d_write = 1'b0; d_size = 3'b100; d_addr = 32'h100; mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("rstwait mem_en", 32'(mem_en1), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait d_ready", 32'(d_ready1), 32'd0);
        chk("rstwait outputs", {mem_en1, mem_we1, mem_be1} | mem_addr1 | d_rdata1 | mem_wdata1, 32'd0);
        rst = 1'b0; d_read = 1'b0;
        @(negedge clk);
        chk("rstwait quiet", 32'(d_ready1), 32'd0);
        data_access("after rst", 1, 0, 3'b100, 0, 32'h100, 0, 32'hCAFEF00D, 4'b1111, 0, 32'hCAFEF00D);

`ifdef MISALIGN_CHECK_EN
        d_read = 1'b1; d_size = 3'b100; d_addr = 32'h102; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("mis mem_en", 32'(mem_en1), 32'd0);
        chk("mis ready+flag", {30'd0, d_ready1, mis1}, 32'd3);
        chk("mis d_rdata", d_rdata1, 32'd0);
        d_read = 1'b0;
        @(negedge clk);
        chk("mis pulse", {29'd0, mem_en1, d_ready1, mis1}, 32'd0);
`endif

        // Starvation: fetch and load held together on both latencies.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; d_read = 1'b1; d_write = 1'b0;
        d_size = 3'b100; d_addr = 32'h200; mem_rdata = 32'h0BADCAFE;
        g1_n = 0; r1_n = 0; g3_n = 0; r3_n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (mem_en1 && g1_n < 16) begin g1_k[g1_n] = (mem_addr1 == 32'h40); g1_c[g1_n] = c; g1_n++; end
            if ((if_ready1 || d_ready1) && r1_n < 16) begin r1_k[r1_n] = if_ready1; r1_c[r1_n] = c; r1_n++; end
            if (mem_en3 && g3_n < 16) begin g3_k[g3_n] = (mem_addr3 == 32'h40); g3_c[g3_n] = c; g3_n++; end
            if ((if_ready3 || d_ready3) && r3_n < 16) begin r3_k[r3_n] = if_ready3; r3_c[r3_n] = c; r3_n++; end
        end
        if_req = 1'b0; d_read = 1'b0;
        chk("starve1 grant count", 32'(g1_n >= 6), 32'd1);
        chk("starve3 grant count", 32'(g3_n >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("starve1 grant %0d", i), 32'(g1_k[i]), 32'(exp_k[i]));
            chk($sformatf("starve1 ready %0d", i), 32'(r1_k[i]), 32'(exp_k[i]));
            chk($sformatf("starve1 latency %0d", i), 32'(r1_c[i] - g1_c[i]), 32'd2);
            chk($sformatf("starve3 grant %0d", i), 32'(g3_k[i]), 32'(exp_k[i]));
            chk($sformatf("starve3 ready %0d", i), 32'(r3_k[i]), 32'(exp_k[i]));
            chk($sformatf("starve3 latency %0d", i), 32'(r3_c[i] - g3_c[i]), 32'd4);
            if (i < 5) begin
                chk($sformatf("starve1 spacing %0d", i), 32'(g1_c[i+1] - g1_c[i]), 32'd4);
                chk($sformatf("starve3 spacing %0d", i), 32'(g3_c[i+1] - g3_c[i]), 32'd6);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the load/store data port.
- Decodes the load/store size and signedness produced by control_unit (memOffset and unsignedFlag): builds byte enables, aligns store data, and sign- or zero-extends load data.
- Sits between the fetch/datapath and the memory macro, and drives a stall to the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_LAT, 1, memory read latency in cycles (≥1), counted from the edge that samples mem_en to the edge after which mem_rdata is valid.
- STARVE_MAX, 4, maximum consecutive data grants while if_req is pending before fetch is forced; 0 means data always wins.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch byte address (word aligned)
- if_rdata  out  32  fetched word; valid when if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- d_read  in  1  load request (control_unit memRead); held until d_ready
- d_write  in  1  store request (control_unit memWrite); held until d_ready
- d_size  in  3  001 byte, 010 half, 100 word (memOffset encoding)
- d_unsigned  in  1  zero-extend loads (unsignedFlag)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, right-justified
- d_rdata  out  32  extended load data; valid when d_ready
- d_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  memory read word
- stall  out  1  (if_req & ~if_ready) | ((d_read|d_write) & ~d_ready), combinational

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE; a latency counter; a starvation counter; a grant register (IF or D).
- Reset: state IDLE; counters 0; if_ready, d_ready, mem_en, mem_we 0; mem_be 0; mem_addr, mem_wdata, if_rdata, d_rdata 0.
- Reset mid-operation: the transaction is abandoned, no ready pulse is issued, and any late mem_rdata is ignored.
- IDLE: requests are sampled only in this state.
  - Data (d_read|d_write) wins over if_req, unless the starvation counter equals STARVE_MAX (STARVE_MAX>0) and if_req is high; then fetch is granted.
  - On grant: go to ISSUE and register the mem_* outputs.
- Starvation counter: increments on each data grant while if_req is high; clears on any fetch grant, or on a data grant with if_req low.
- ISSUE: mem_en=1 for exactly this one cycle, with mem_we = d_write for a data grant; then go to WAIT and set the counter to 1.
- WAIT: the counter increments each edge. At the edge where the counter equals MEM_LAT, capture mem_rdata and go to DONE.
- DONE: the granted port's ready is 1 for this one cycle, with rdata valid; then go to IDLE unconditionally, without sampling.
  - Reason: requests seen at that edge are the old, already-served request.
- Latency: grant edge E0 → ready high during the cycle after E(MEM_LAT+1). Back-to-back accesses start MEM_LAT+3 cycles apart.
- Stores follow the same timing and also pulse d_ready.
- Byte enables:
  - byte: 0001<<a[1:0]
  - half: 0011<<{a[1],1'b0}
  - word: 1111
- mem_wdata: byte replicated ×4, half replicated ×2, word passed through.
- Loads select the lane with addr[1:0]. d_unsigned=0 sign-extends; d_unsigned=1 zero-extends. Word loads ignore d_unsigned.
- d_size values other than 001/010/100 are treated as word.
- Fetch always uses mem_be=1111 and mem_we=0.
- d_read and d_write both high: treated as a store.
- Simultaneous if_req and data request in IDLE: resolved by the priority rule above; the loser waits and its stall stays high.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - A half access with a[0]=1, or a word access with a[1:0]≠00, raises the output d_misalign (1 bit).
  - No memory access occurs (mem_en stays 0). The FSM goes IDLE→DONE directly; d_ready and d_misalign pulse together; d_rdata=0.
- Undefined: no d_misalign port. Misaligned addresses are truncated to the lane rules above and the access proceeds normally.

Test Plan:
- Reset during WAIT of a load (MEM_LAT=1) → no d_ready pulse, all outputs 0 on the next cycle, the next request is served normally.
- if_req with if_addr=0x40 and mem_rdata=0x00500093, MEM_LAT=1 → mem_en one cycle after the grant edge, if_ready with if_rdata=0x00500093 two edges after the grant, stall high until then.
- Load byte signed (d_size=001, d_unsigned=0), addr 0x103, mem_rdata 0x80FF1234 → mem_be=1000, d_rdata=0xFFFFFF80. Same access with d_unsigned=1 → 0x00000080.
- Store half, addr 0x102, d_wdata 0x0000BEEF → mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, d_ready pulse, no if_ready.
- if_req and d_read both held continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D…
  - Repeat with MEM_LAT=3: each ready appears 4 edges after its grant.
- With MISALIGN_CHECK_EN: word load at 0x102 → mem_en never asserted, d_ready and d_misalign high in the same cycle, d_rdata=0.
